// File: rtl/demux_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin demux scheduler.
package demux_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/demux_rr_scheduler_if.sv
// Producer/consumer bus of the demux scheduler; master is the environment, slave the scheduler.
// The drop pulse exists only when DEMUX_SCHED_TIMEOUT_EN is defined.
interface demux_rr_scheduler_if
    import demux_sched_pkg::*;
#(
    parameter int W = 8
);

    logic              in_valid;
    logic [W-1:0]      in_data;
    logic              in_ready;
    logic [NUM_CH-1:0] chan_en;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] out_valid;
    logic [W-1:0]      out_data;
    logic [NUM_CH-1:0] out_ready;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    logic              drop;
`endif

    modport master (
        output in_valid, in_data, chan_en, out_ready,
        input  in_ready, sel, out_valid, out_data
`ifdef DEMUX_SCHED_TIMEOUT_EN
        , input drop
`endif
    );

    modport slave (
        input  in_valid, in_data, chan_en, out_ready,
        output in_ready, sel, out_valid, out_data
`ifdef DEMUX_SCHED_TIMEOUT_EN
        , output drop
`endif
    );

endinterface

// File: rtl/demux_rr_scheduler_rr_pick.sv
// Rotate-priority finder: first set bit of mask at or after ptr, wrapping modulo NUM_CH.
module rr_pick
    import demux_sched_pkg::*;
(
    input  logic [SEL_W-1:0]  ptr,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [SEL_W-1:0] cand;

    // Scan from the far end back toward ptr so the nearest enabled channel wins.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (mask[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler for the 1-to-8 demux: single-entry hold register, rotating channel pick.
// Optional stall timeout with drop pulse under DEMUX_SCHED_TIMEOUT_EN.
module demux_rr_scheduler
    import demux_sched_pkg::*;
#(
    parameter int W = 8
`ifdef DEMUX_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
)(
    input  logic                 clk,
    input  logic                 rst,
    demux_rr_scheduler_if.slave  bus
);

    state_t            state_p0;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  sel_p0;
    logic [NUM_CH-1:0] vld_p0;
    logic [W-1:0]      data_p0;
    logic              rst_done;

    logic [SEL_W-1:0]  pick;
    logic              any;
    logic              fire;
    logic              release_now;
    logic              ready;
    logic              accept;

    rr_pick u_pick (
        .ptr  (ptr),
        .mask (bus.chan_en),
        .idx  (pick),
        .any  (any)
    );

    assign fire = (state_p0 == FULL) && bus.out_ready[sel_p0];

`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;
    logic             stall;
    logic             hit;
    logic             drop_p0;

    assign stall       = (state_p0 == FULL) && !bus.out_ready[sel_p0];
    assign hit         = stall && (stall_cnt == CNT_W'(TIMEOUT - 1));
    // A timeout edge frees the register just like a fire, so a new item may load on it.
    assign release_now = fire || hit;
`else
    assign release_now = fire;
`endif

    // rst_done keeps in_ready low until the first edge after reset is released.
    assign ready  = rst_done && ((state_p0 == EMPTY) || release_now) && any;
    assign accept = bus.in_valid && ready;

    // Stage p0: hold register, channel select and rotation pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p0 <= EMPTY;
            ptr      <= '0;
            sel_p0   <= '0;
            vld_p0   <= '0;
            data_p0  <= '0;
            rst_done <= 1'b0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
            stall_cnt <= '0;
            drop_p0   <= 1'b0;
`endif
        end else begin
            rst_done <= 1'b1;
            if (accept) begin
                state_p0 <= FULL;
                data_p0  <= bus.in_data;
                sel_p0   <= pick;
                ptr      <= pick + SEL_W'(1);
                vld_p0   <= onehot(pick);
            end else if (release_now) begin
                state_p0 <= EMPTY;
                vld_p0   <= '0;
                data_p0  <= '0;
            end
`ifdef DEMUX_SCHED_TIMEOUT_EN
            drop_p0 <= hit;
            if (accept)
                stall_cnt <= '0;
            else if (stall && !hit)
                stall_cnt <= stall_cnt + CNT_W'(1);
`endif
        end
    end

    assign bus.in_ready  = ready;
    assign bus.sel       = sel_p0;
    assign bus.out_valid = vld_p0;
    assign bus.out_data  = data_p0;
`ifdef DEMUX_SCHED_TIMEOUT_EN
    assign bus.drop      = drop_p0;
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed self-checking bench for demux_rr_scheduler (timeout section built only with DEMUX_SCHED_TIMEOUT_EN).
module tb_demux_rr_scheduler;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    demux_rr_scheduler_if #(.W(8)) bus ();

    demux_rr_scheduler #(
        .W(8)
`ifdef DEMUX_SCHED_TIMEOUT_EN
        , .TIMEOUT(4)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] seq25 [4];
        n_checks = 0;
        n_fail   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.chan_en   = 8'hFF;
        bus.out_ready = 8'hFF;
        tick();
        tick();
        chk("rst_vld",   bus.out_valid, 8'h00);
        chk("rst_data",  bus.out_data,  8'h00);
        chk("rst_sel",   bus.sel,       3'd0);
        chk("rst_ready", bus.in_ready,  1'b0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", bus.in_ready, 1'b0);
        tick();
        chk("ready_after_edge", bus.in_ready, 1'b1);

        // Back-to-back, all channels enabled, ninth item wraps to channel 0.
        for (int k = 0; k < 9; k++) begin
            d = 8'((k + 1) * 17);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            #1;
            chk("b2b_ready", bus.in_ready, 1'b1);
            tick();
            chk("b2b_sel",  bus.sel,       32'(k % 8));
            chk("b2b_vld",  bus.out_valid, 32'(8'h01 << (k % 8)));
            chk("b2b_data", bus.out_data,  d);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("b2b_drain", bus.out_valid, 8'h00);
        chk("b2b_drain_data", bus.out_data, 8'h00);

        // Two enabled channels alternate; pointer sits at 1 here.
        bus.chan_en = 8'b0010_0100;
        seq25[0] = 8'h02; seq25[1] = 8'h05; seq25[2] = 8'h02; seq25[3] = 8'h05;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h30 + k);
            tick();
            chk("alt_sel",  bus.sel,       seq25[k]);
            chk("alt_vld",  bus.out_valid, (seq25[k] == 8'h02) ? 8'h04 : 8'h20);
            chk("alt_data", bus.out_data,  8'(8'h30 + k));
        end
        bus.in_valid = 1'b0;
        tick();

        // Hold on channel 3 while its enable drops; other channels' ready is ignored.
        bus.chan_en   = 8'h08;
        bus.out_ready = 8'h00;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        tick();
        chk("hold_sel", bus.sel, 3'd3);
        bus.chan_en   = 8'hF7;
        bus.out_ready = 8'hF7;
        bus.in_data   = 8'h5A;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_ready", bus.in_ready,  1'b0);
            chk("hold_vld",   bus.out_valid, 8'h08);
            chk("hold_data",  bus.out_data,  8'hA5);
            tick();
        end
        bus.out_ready = 8'hFF;
        #1;
        chk("hold_release_ready", bus.in_ready, 1'b1);
        tick();
        chk("hold_next_sel",  bus.sel,       3'd4);
        chk("hold_next_vld",  bus.out_valid, 8'h10);
        chk("hold_next_data", bus.out_data,  8'h5A);
        bus.in_valid = 1'b0;
        tick();
        chk("hold_empty", bus.out_valid, 8'h00);

        // No channel enabled: nothing accepted; then only channel 6.
        bus.chan_en  = 8'h00;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h66;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("none_ready", bus.in_ready,  1'b0);
            chk("none_vld",   bus.out_valid, 8'h00);
            tick();
        end
        bus.chan_en = 8'h40;
        #1;
        chk("en6_ready", bus.in_ready, 1'b1);
        tick();
        chk("en6_sel",  bus.sel,       3'd6);
        chk("en6_vld",  bus.out_valid, 8'h40);
        chk("en6_data", bus.out_data,  8'h66);

        // Reset while full clears the held item at once.
        bus.in_valid  = 1'b0;
        bus.out_ready = 8'h00;
        tick();
        chk("pre_rst_vld", bus.out_valid, 8'h40);
        rst = 1'b1;
        #1;
        chk("mid_rst_vld",  bus.out_valid, 8'h00);
        chk("mid_rst_data", bus.out_data,  8'h00);
        chk("mid_rst_sel",  bus.sel,       3'd0);
        tick();
        rst           = 1'b0;
        bus.chan_en   = 8'hFF;
        bus.out_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        #1;
        chk("post_rst_ready0", bus.in_ready, 1'b0);
        tick();
        chk("post_rst_vld0", bus.out_valid, 8'h00);
        chk("post_rst_ready1", bus.in_ready, 1'b1);
        tick();
        chk("post_rst_sel",  bus.sel,      3'd0);
        chk("post_rst_data", bus.out_data, 8'h77);
        bus.in_valid = 1'b0;
        tick();

`ifdef DEMUX_SCHED_TIMEOUT_EN
        // Stalled item on channel 1 drops on the fourth stall edge.
        bus.out_ready = 8'h00;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h99;
        tick();
        chk("to_sel", bus.sel, 3'd1);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_nodrop", bus.drop,      1'b0);
            chk("to_vld",    bus.out_valid, 8'h02);
        end
        tick();
        chk("to_drop",     bus.drop,      1'b1);
        chk("to_drop_vld", bus.out_valid, 8'h00);
        tick();
        chk("to_drop_end", bus.drop, 1'b0);
        bus.out_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAB;
        tick();
        chk("to_next_sel",  bus.sel,      3'd2);
        chk("to_next_data", bus.out_data, 8'hAB);
        bus.in_valid = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_rr_scheduler.md
# demux_rr_scheduler

Round-robin scheduler that sequences the 1-to-8 demultiplexer datapath. It accepts a valid/ready input stream, picks the next enabled output channel in rotating order, and drives the demux select together with a one-hot valid. It holds each item in a single-entry output register until the chosen channel accepts it. It sits between an upstream producer and eight downstream consumers that share one data bus.

## Interface
- W, 8, data width of each item
- TIMEOUT, 16, stall cycles before a held item is dropped (only used with DEMUX_SCHED_TIMEOUT_EN)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream item available
- in_data  input  W  upstream item
- in_ready  output  1  scheduler accepts in_data this cycle
- chan_en  input  8  per-channel enable mask; disabled channels are skipped
- sel  output  3  demux select; index of the channel owning the held item
- out_valid  output  8  one-hot valid for channel sel; all zero when empty
- out_data  output  W  held item; zero when empty
- out_ready  input  8  per-channel accept
- drop  output  1  one-cycle pulse when a held item is discarded (only with DEMUX_SCHED_TIMEOUT_EN)

## Operation
- State machine with two states. EMPTY means no item is held. FULL means an item is held for channel sel.
- Pointer ptr (3 bits) marks the highest-priority channel for the next pick.
- Pick: the first i in ptr, ptr+1, …, ptr+7 (mod 8) with chan_en[i]=1. This is combinational from the current ptr and chan_en.
- fire = FULL && out_ready[sel].
- in_ready = (EMPTY || fire) && |chan_en.
- accept = in_valid && in_ready.
- On accept:
  - data register <= in_data
  - sel <= pick
  - ptr <= pick+1 (mod 8, wraps 7→0)
  - state → FULL
- fire without accept: state → EMPTY. sel holds its value, ptr is unchanged.
- Simultaneous fire and accept in the same cycle: the old item leaves and the new item loads. The new pick uses the current ptr, which already points past the old item's channel.
- Changes to chan_en while FULL never retarget the held item. It waits on its original channel.
- chan_en = 0: in_ready = 0, nothing is accepted, and any held item still drains normally.
- out_ready on channels other than sel is ignored.

## Timing
- Reset values: state EMPTY, ptr 0, sel 0, data register 0, out_valid 0, out_data 0, in_ready 0 until the first edge after rst falls (then per the rule above), drop 0.
- Latency: an item accepted at edge N is visible on out_valid/out_data/sel after edge N.
- Throughput: one item per cycle when the consumers keep out_ready high, because fire and accept overlap.
- in_ready has a combinational path from out_ready[sel] and chan_en. All other outputs are registered.
- rst asserted mid-transfer clears the held item immediately, with no drop pulse.

## Configuration
- DEMUX_SCHED_TIMEOUT_EN defined:
  - A stall counter counts cycles in FULL without fire, and resets to 0 on every load.
  - When the counter reaches TIMEOUT-1 while still stalled, the next edge sets state to EMPTY and pulses drop for one cycle. ptr is unchanged.
  - Accept in that same cycle is allowed: in_ready treats the timeout edge as a fire.
- Undefined: no counter, no drop port; the held item waits indefinitely.

## Structure
- Package demux_sched_pkg holds:
  - NUM_CH = 8
  - SEL_W = 3
  - state typedef {EMPTY, FULL}
- Sub-module rr_pick: combinational rotate-priority finder. Inputs are ptr[2:0] and mask[7:0]; outputs are idx[2:0] and any.

## Test plan
- All enabled, out_ready = 8'hFF, items 0x11…0x88 back-to-back → one per cycle on sel 0,1,…,7. The ninth item lands on sel 0 (wrap).
- chan_en = 8'b0010_0100, continuous input → sel alternates 2,5,2,5; out_valid alternates 8'h04, 8'h20.
- Item 0xA5 held on sel 3 with out_ready[3]=0 for 5 cycles while chan_en[3] drops → out_valid stays 8'h08. The item fires when out_ready[3]=1 and in_ready stays low until then.
- chan_en = 0 with in_valid=1 → in_ready=0, out_valid=0 indefinitely. Enabling bit 6 → the next item goes to sel 6.
- rst asserted while FULL → out_valid=0, out_data=0, sel=0 immediately. After release the first item goes to sel 0.
- With DEMUX_SCHED_TIMEOUT_EN and TIMEOUT=4, out_ready=0 → drop pulses on the 4th stall edge, out_valid goes to 0, and the next item goes to the following enabled channel.
